// File: rtl/fifo_burst_arbiter.sv
// fifo_burst_arbiter
// Round-robin burst arbiter that drains two fifo_sync sources onto one
// valid/ready stream. Source reads are issued only when a slot in the 4-entry
// output buffer is guaranteed, which accounts for the one-cycle read latency.
//
// Ports
//   i_clk, i_rst        clock, asynchronous active-high reset
//   i_fill0/1           fill counts of the source FIFOs
//   i_data0/1           source FIFO read data (valid the cycle after o_rdN)
//   o_rd0/1             read strobes to the source FIFOs (never both high)
//   i_flush             level; lets a non-empty source below BURST_LEN be granted
//   o_data/o_src/o_last output word, its source index, and its end-of-burst flag
//   o_valid/i_ready     output handshake
//   o_busy              high in a burst or while the output buffer holds data
module fifo_burst_arbiter #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 9,
  parameter int unsigned BURST_LEN  = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [ADDR_WIDTH:0]   i_fill0,
  input  logic [DATA_WIDTH-1:0] i_data0,
  output logic                  o_rd0,
  input  logic [ADDR_WIDTH:0]   i_fill1,
  input  logic [DATA_WIDTH-1:0] i_data1,
  output logic                  o_rd1,
  input  logic                  i_flush,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_src,
  output logic                  o_last,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic                  o_busy
);

  localparam int unsigned FillW = ADDR_WIDTH + 1;
  localparam int unsigned EntW  = DATA_WIDTH + 2;
  localparam logic [FillW-1:0] BurstCnt = FillW'(BURST_LEN);

  typedef enum logic [0:0] {StIdle, StBurst} state_e;

  state_e           state_q, state_d;
  logic             src_q, src_d;
  logic [FillW-1:0] rem_q, rem_d;
  // Source favoured when both are eligible; flips to the other after each burst.
  logic             rr_q, rr_d;

  // Tags for the read issued last cycle, whose data is on i_dataN this cycle.
  logic             infl_q, infl_src_q, infl_last_q;

  logic [EntW-1:0]  mem_q [4];
  logic [1:0]       wr_ptr_q, rd_ptr_q;
  logic [2:0]       occ_q;

  logic             elig0, elig1;
  logic [FillW-1:0] fill_sel;
  logic             rd_en, push, pop;
  logic [EntW-1:0]  head;

  assign elig0 = (i_fill0 >= BurstCnt) || (i_flush && (i_fill0 != '0));
  assign elig1 = (i_fill1 >= BurstCnt) || (i_flush && (i_fill1 != '0));

  // Credit check: buffered words plus the word still in flight must leave room.
  assign rd_en = (state_q == StBurst) && ((occ_q + {2'b00, infl_q}) < 3'd4);
  assign push  = infl_q;
  assign pop   = (occ_q != 3'd0) && i_ready;
  assign head  = mem_q[rd_ptr_q];

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= StIdle;
      src_q   <= 1'b0;
      rem_q   <= '0;
      rr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      rem_q   <= rem_d;
      rr_q    <= rr_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    src_d    = src_q;
    rem_d    = rem_q;
    rr_d     = rr_q;
    fill_sel = '0;
    unique case (state_q)
      StIdle: begin
        if (elig0 || elig1) begin
          src_d    = (elig0 && elig1) ? rr_q : elig1;
          fill_sel = src_d ? i_fill1 : i_fill0;
          rem_d    = (fill_sel >= BurstCnt) ? BurstCnt : fill_sel;
          state_d  = StBurst;
        end
      end
      StBurst: begin
        if (rd_en) begin
          rem_d = rem_q - 1'b1;
          if (rem_q == FillW'(1)) begin
            state_d = StIdle;
            rr_d    = ~src_q;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    o_rd0   = rd_en && !src_q;
    o_rd1   = rd_en && src_q;
    o_valid = (occ_q != 3'd0);
    o_data  = o_valid ? head[DATA_WIDTH-1:0] : '0;
    o_src   = o_valid ? head[DATA_WIDTH] : 1'b0;
    o_last  = o_valid ? head[DATA_WIDTH+1] : 1'b0;
    o_busy  = (state_q == StBurst) || o_valid;
  end

  // In-flight tags and buffer pointers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      infl_q      <= 1'b0;
      infl_src_q  <= 1'b0;
      infl_last_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      occ_q       <= '0;
    end else begin
      infl_q      <= rd_en;
      infl_src_q  <= src_q;
      infl_last_q <= rd_en && (rem_q == FillW'(1));
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      occ_q <= occ_q + {2'b00, push} - {2'b00, pop};
    end
  end

  // Buffer storage needs no reset; entries are only visible once written.
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {infl_last_q, infl_src_q, (infl_src_q ? i_data1 : i_data0)};
    end
  end

endmodule
